rotary_quad_conditioner: RTL and testbench



---
 rtl/rotary_quad_conditioner.sv | 121 ++++++++++++
 tb/tb_rotary_quad_conditioner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_quad_conditioner.sv
// Rotary encoder front end: per-pin synchroniser and debouncer, A-rise detent
// decoding with direction from B, and a wrapped detent position counter.
module rotary_quad_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int DETENTS         = 20,
   parameter int POS_W           = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enc_a,
   input  logic             enc_b,
   output logic             a_db,
   output logic             b_db,
   output logic             step,
   output logic             dir,
   output logic [POS_W-1:0] pos
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(DETENTS - 1);
   localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
   localparam logic [POS_W-1:0] POS_ZERO = POS_W'(0);

   logic [SYNC_STAGES-1:0]     a_sync_r;
   logic [SYNC_STAGES-1:0]     b_sync_r;
   logic [1:0]                 sync_s;
   logic [1:0]                 db_r;
   logic [1:0][CNT_W-1:0]      cnt_r;
   logic                       a_db_q_r;
   logic                       b_db_q_r;
   logic                       rise_s;
   logic                       dir_next_s;
   logic [POS_W-1:0]           pos_next_s;
   logic                       step_r;
   logic                       dir_r;
   logic [POS_W-1:0]           pos_r;

   // Shift each raw pin into its synchroniser chain; chains idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sync_r <= {SYNC_STAGES{1'b1}};
         b_sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         a_sync_r <= {a_sync_r[SYNC_STAGES-2:0], enc_a};
         b_sync_r <= {b_sync_r[SYNC_STAGES-2:0], enc_b};
      end
   end

   // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_r  <= 2'b11;
         cnt_r <= {2{CNT_ZERO}};
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_s[i] == db_r[i]) begin
               cnt_r[i] <= CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
               db_r[i]  <= sync_s[i];
               cnt_r[i] <= CNT_ZERO;
            end else begin
               cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
         end
      end
   end

   // Rise detect and next position; direction uses B as registered alongside the A rise.
   always_comb begin
      sync_s     = {b_sync_r[SYNC_STAGES-1], a_sync_r[SYNC_STAGES-1]};
      rise_s     = db_r[0] & ~a_db_q_r;
      dir_next_s = ~b_db_q_r;
      pos_next_s = pos_r;
      if (dir_next_s) begin
         if (pos_r == POS_LAST) begin
            pos_next_s = POS_ZERO;
         end else begin
            pos_next_s = pos_r + POS_ONE;
         end
      end else begin
         if (pos_r == POS_ZERO) begin
            pos_next_s = POS_LAST;
         end else begin
            pos_next_s = pos_r - POS_ONE;
         end
      end
   end

   // Registered step/dir/pos; pos and dir move only on the cycle step is raised.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_db_q_r <= 1'b1;
         b_db_q_r <= 1'b1;
         step_r   <= 1'b0;
         dir_r    <= 1'b1;
         pos_r    <= POS_ZERO;
      end else begin
         a_db_q_r <= db_r[0];
         b_db_q_r <= db_r[1];
         step_r   <= rise_s;
         if (rise_s) begin
            dir_r <= dir_next_s;
            pos_r <= pos_next_s;
         end else begin
            dir_r <= dir_r;
            pos_r <= pos_r;
         end
      end
   end

   assign a_db = db_r[0];
   assign b_db = db_r[1];
   assign step = step_r;
   assign dir  = dir_r;
   assign pos  = pos_r;

endmodule

// File: tb/tb_rotary_quad_conditioner.sv
// Randomised and directed bench for rotary_quad_conditioner against a
// cycle-level behavioural model built from pin histories and modular arithmetic.
module tb_rotary_quad_conditioner;

   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int CNT_W           = 3;
   localparam int DETENTS         = 20;
   localparam int POS_W           = 5;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             enc_a = 1'b1;
   logic             enc_b = 1'b1;
   logic             a_db;
   logic             b_db;
   logic             step;
   logic             dir;
   logic [POS_W-1:0] pos;

   int tests_run    = 0;
   int tests_failed = 0;
   int steps_seen   = 0;

   // Model state: pin delay queues, debounced levels with run lengths, history of levels.
   bit q_a[$];
   bit q_b[$];
   bit m_sync_a, m_sync_b;
   bit m_db_a, m_db_b;
   int run_a, run_b;
   bit dba2, dbb2;
   bit m_step, m_dir;
   int m_pos;

   always #5 clk = ~clk;

   rotary_quad_conditioner #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .DETENTS        (DETENTS),
      .POS_W          (POS_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .enc_a(enc_a),
      .enc_b(enc_b),
      .a_db (a_db),
      .b_db (b_db),
      .step (step),
      .dir  (dir),
      .pos  (pos)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q_a = {};
      q_b = {};
      for (int i = 0; i < SYNC_STAGES - 1; i++) begin
         q_a.push_back(1'b1);
         q_b.push_back(1'b1);
      end
      m_sync_a = 1'b1; m_sync_b = 1'b1;
      m_db_a   = 1'b1; m_db_b   = 1'b1;
      run_a    = 0;    run_b    = 0;
      dba2     = 1'b1; dbb2     = 1'b1;
      m_step   = 1'b0; m_dir    = 1'b1;
      m_pos    = 0;
   endtask

   function automatic void debounce(input bit s, inout bit db, inout int run);
      if (s != db) begin
         run++;
         if (run == DEBOUNCE_CYCLES) begin
            db  = s;
            run = 0;
         end
      end else begin
         run = 0;
      end
   endfunction

   // One rising edge of the model, using the pin levels present before the edge.
   task automatic model_edge();
      bit rise;
      if (!rst_n) begin
         model_reset();
         return;
      end
      rise   = m_db_a && !dba2;
      m_step = rise;
      if (rise) begin
         m_dir = !dbb2;
         m_pos = m_dir ? (m_pos + 1) % DETENTS : (m_pos + DETENTS - 1) % DETENTS;
      end
      dba2 = m_db_a;
      dbb2 = m_db_b;
      debounce(m_sync_a, m_db_a, run_a);
      debounce(m_sync_b, m_db_b, run_b);
      m_sync_a = q_a.pop_front();
      m_sync_b = q_b.pop_front();
      q_a.push_back(enc_a);
      q_b.push_back(enc_b);
   endtask

   task automatic check_outputs(input string ph);
      check_val({ph, ".a_db"}, a_db, m_db_a);
      check_val({ph, ".b_db"}, b_db, m_db_b);
      check_val({ph, ".step"}, step, m_step);
      check_val({ph, ".dir"},  dir,  m_dir);
      check_val({ph, ".pos"},  pos,  m_pos);
      if (step) steps_seen++;
   endtask

   task automatic tick(input string ph);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(ph);
   endtask

   task automatic pulse_reset(input string ph);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs({ph, ".async"});
      enc_a = 1'b1;
      enc_b = 1'b1;
      repeat (2) tick({ph, ".hold"});
      rst_n = 1'b1;
   endtask

   task automatic detent(input bit b);
      enc_b = b;
      enc_a = 1'b0;
      repeat (10) tick("detent");
      enc_a = 1'b1;
      repeat (10) tick("detent");
   endtask

   int lat;
   int a_lat;
   int exp_ccw[3] = '{19, 18, 17};

   initial begin
      model_reset();

      // Reset held with toggling pins, then idle-high with no steps.
      for (int i = 0; i < 6; i++) begin
         enc_a = i[0];
         enc_b = ~i[0];
         tick("reset");
      end
      enc_a = 1'b1;
      enc_b = 1'b1;
      rst_n = 1'b1;
      steps_seen = 0;
      repeat (20) tick("idle");
      check_val("idle_steps", steps_seen, 0);

      // Single clockwise detent with exact latency.
      enc_b = 1'b0;
      enc_a = 1'b0;
      repeat (20) tick("cw_low");
      enc_a = 1'b1;
      lat = 0; a_lat = 0; steps_seen = 0;
      for (int i = 1; i <= 40; i++) begin
         tick("cw");
         if (a_db && a_lat == 0) a_lat = i;
         if (step && lat == 0) lat = i;
      end
      check_val("cw_adb_latency", a_lat, 6);
      check_val("cw_step_latency", lat, 7);
      check_val("cw_steps", steps_seen, 1);
      check_val("cw_pos", pos, 1);
      check_val("cw_dir", dir, 1);

      // Counter-clockwise wrap from zero.
      pulse_reset("ccw_rst");
      for (int i = 0; i < 3; i++) begin
         steps_seen = 0;
         detent(1'b1);
         check_val("ccw_steps", steps_seen, 1);
         check_val("ccw_pos", pos, exp_ccw[i]);
         check_val("ccw_dir", dir, 0);
      end

      // Clockwise wrap through DETENTS-1.
      pulse_reset("cwwrap_rst");
      for (int i = 0; i < 19; i++) detent(1'b0);
      check_val("cwwrap_pre_pos", pos, 19);
      detent(1'b0);
      check_val("cwwrap_pos", pos, 0);
      check_val("cwwrap_dir", dir, 1);

      // Short glitch is rejected.
      steps_seen = 0;
      enc_a = 1'b0;
      repeat (3) tick("glitch");
      enc_a = 1'b1;
      repeat (12) tick("glitch");
      check_val("glitch_steps", steps_seen, 0);
      check_val("glitch_adb", a_db, 1);

      // Bouncy rise yields exactly one step.
      enc_a = 1'b0;
      repeat (10) tick("bounce_low");
      steps_seen = 0;
      enc_a = 1'b1; tick("bounce");
      enc_a = 1'b0; tick("bounce");
      enc_a = 1'b1;
      lat = 0;
      for (int i = 1; i <= 15; i++) begin
         tick("bounce");
         if (step && lat == 0) lat = i;
      end
      check_val("bounce_steps", steps_seen, 1);
      check_val("bounce_latency", lat, 7);

      // Reset during a partial A debounce.
      pulse_reset("mid_rst0");
      for (int i = 0; i < 7; i++) detent(1'b0);
      check_val("mid_pre_pos", pos, 7);
      enc_a = 1'b0;
      repeat (4) tick("mid_count");
      pulse_reset("mid_rst");
      check_val("mid_pos", pos, 0);
      check_val("mid_adb", a_db, 1);
      steps_seen = 0;
      repeat (20) tick("mid_after");
      check_val("mid_steps", steps_seen, 0);

      // Random pin activity with occasional resets.
      for (int it = 0; it < 200; it++) begin
         if ($urandom_range(0, 40) == 0) pulse_reset("rand_rst");
         enc_b = 1'($urandom_range(0, 1));
         enc_a = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 12)) tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
